// File: rtl/mem_pkg.sv
// Shared types and lane helpers for the word-wide memory initiator.
package mem_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    RD0  = 4'd1,
    RD1  = 4'd2,
    WS0  = 4'd3,
    WP0  = 4'd4,
    WH0  = 4'd5,
    WS1  = 4'd6,
    WP1  = 4'd7,
    WH1  = 4'd8,
    DONE = 4'd9
  } state_e;

  // Byte-lane masks for an access starting at lane 0.
  localparam logic [3:0] LANES_NONE = 4'b0000;
  localparam logic [3:0] LANES_BYTE = 4'b0001;
  localparam logic [3:0] LANES_HALF = 4'b0011;
  localparam logic [3:0] LANES_WORD = 4'b1111;

  function automatic logic [3:0] lane_mask(input size_e sz);
    case (sz)
      SZ_BYTE: return LANES_BYTE;
      SZ_HALF: return LANES_HALF;
      SZ_WORD: return LANES_WORD;
      default: return LANES_NONE;
    endcase
  endfunction

  function automatic logic [2:0] size_bytes(input size_e sz);
    case (sz)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      SZ_WORD: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  // Access touches two words when it runs past lane 3.
  function automatic logic is_split(input logic [1:0] off, input size_e sz);
    return ({1'b0, off} + size_bytes(sz)) > 3'd4;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] off, input size_e sz);
    case (sz)
      SZ_HALF: return off[0];
      SZ_WORD: return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_initiator_if.sv
// Memory responder bus: word address, active-low strobes, write/read data.
interface mem_initiator_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] ADDR;
  logic              N_OE;
  logic              N_WE;
  logic [DATA_W-1:0] MEM_WDATA;
  logic [DATA_W-1:0] MEM_RDATA;

  modport master (output ADDR, output N_OE, output N_WE, output MEM_WDATA, input MEM_RDATA);
  modport slave  (input ADDR, input N_OE, input N_WE, input MEM_WDATA, output MEM_RDATA);
endinterface

// File: rtl/mem_lane_merge.sv
// Combinational lane logic: merged store words for word0/word1 and the
// right-justified, extended load result gathered across both words.
module mem_lane_merge
  import mem_pkg::*;
(
  input  logic [1:0]  off,
  input  size_e       size,
  input  logic        is_signed,
  input  logic [31:0] wdata,
  input  logic [31:0] word0,
  input  logic [31:0] word1,
  output logic [31:0] merged0,
  output logic [31:0] merged1,
  output logic [31:0] load_data
);

  logic [7:0]  lane_mask_s;
  logic [63:0] bit_mask_s;
  logic [63:0] wdata_sh_s;
  logic [31:0] load_al_s;

  // Build the two-word lane mask, place the store data and pull out the load bytes.
  always_comb begin
    lane_mask_s = {4'b0000, lane_mask(size)} << off;
    bit_mask_s  = 64'h0;
    for (int k = 0; k < 8; k++) begin
      bit_mask_s[8*k +: 8] = {8{lane_mask_s[k]}};
    end
    wdata_sh_s = {32'h0, wdata} << {off, 3'b000};
    merged0    = (word0 & ~bit_mask_s[31:0])  | (wdata_sh_s[31:0]  & bit_mask_s[31:0]);
    merged1    = (word1 & ~bit_mask_s[63:32]) | (wdata_sh_s[63:32] & bit_mask_s[63:32]);
    load_al_s  = 32'({word1, word0} >> {off, 3'b000});
    case (size)
      SZ_BYTE: load_data = {{24{is_signed & load_al_s[7]}},  load_al_s[7:0]};
      SZ_HALF: load_data = {{16{is_signed & load_al_s[15]}}, load_al_s[15:0]};
      default: load_data = load_al_s;
    endcase
  end

endmodule

// File: rtl/mem_initiator.sv
// Load/store request port to word-wide memory bus master.
// Optional macro ALIGN_FAULT_EN: reject non-naturally-aligned half/word
// requests with ACK+FAULT instead of splitting/merging them.
module mem_initiator
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ,
  input  logic              REQ_WE,
  input  logic [1:0]        REQ_SIZE,
  input  logic              REQ_SIGNED,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [DATA_W-1:0] REQ_WDATA,
  output logic              ACK,
  output logic              FAULT,
  output logic [DATA_W-1:0] RDATA,
  output logic              BUSY,
  mem_initiator_if.master   bus
);

  state_e            state_q, state_d;
  logic              req_we_q, req_we_d;
  size_e             req_size_q, req_size_d;
  logic              req_signed_q, req_signed_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
  logic              split_q, split_d;
  logic [DATA_W-1:0] word0_q, word0_d, word1_q, word1_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              n_oe_q, n_oe_d, n_we_q, n_we_d;
  logic              ack_q, ack_d, fault_q, fault_d, busy_q, busy_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              reject_s;
  logic [ADDR_W-1:0] base_s;
  logic [DATA_W-1:0] word0_s, word1_s, merged0_s, merged1_s, load_s;

`ifdef ALIGN_FAULT_EN
  assign reject_s = (size_e'(REQ_SIZE) == SZ_RSVD) || is_misaligned(REQ_ADDR[1:0], size_e'(REQ_SIZE));
`else
  assign reject_s = (size_e'(REQ_SIZE) == SZ_RSVD);
`endif

  // Words seen by the lane logic: live bus data while it is being read, else the captured copy.
  assign word0_s = (state_q == RD0) ? bus.MEM_RDATA : word0_q;
  assign word1_s = (state_q == RD1) ? bus.MEM_RDATA : word1_q;
  assign base_s  = (state_q == IDLE) ? {REQ_ADDR[ADDR_W-1:2], 2'b00} : {req_addr_q[ADDR_W-1:2], 2'b00};

  mem_lane_merge u_lane (
    .off       (req_addr_q[1:0]),
    .size      (req_size_q),
    .is_signed (req_signed_q),
    .wdata     (req_wdata_q),
    .word0     (word0_s),
    .word1     (word1_s),
    .merged0   (merged0_s),
    .merged1   (merged1_s),
    .load_data (load_s)
  );

  // Next state, request latching and bus outputs derived from the state being entered.
  always_comb begin
    state_d      = state_q;
    req_we_d     = req_we_q;
    req_size_d   = req_size_q;
    req_signed_d = req_signed_q;
    req_addr_d   = req_addr_q;
    req_wdata_d  = req_wdata_q;
    split_d      = split_q;
    word0_d      = word0_q;
    word1_d      = word1_q;
    fault_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (REQ) begin
          req_we_d     = REQ_WE;
          req_size_d   = size_e'(REQ_SIZE);
          req_signed_d = REQ_SIGNED;
          req_addr_d   = REQ_ADDR;
          req_wdata_d  = REQ_WDATA;
          split_d      = is_split(REQ_ADDR[1:0], size_e'(REQ_SIZE));
          if (reject_s) begin
            state_d = DONE;
            fault_d = 1'b1;
          end else if (REQ_WE && (size_e'(REQ_SIZE) == SZ_WORD) && (REQ_ADDR[1:0] == 2'b00)) begin
            state_d = WS0;
          end else begin
            state_d = RD0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RD0: begin
        word0_d = bus.MEM_RDATA;
        state_d = split_q ? RD1 : (req_we_q ? WS0 : DONE);
      end
      RD1: begin
        word1_d = bus.MEM_RDATA;
        state_d = req_we_q ? WS0 : DONE;
      end
      WS0:     state_d = WP0;
      WP0:     state_d = WH0;
      WH0:     state_d = split_q ? WS1 : DONE;
      WS1:     state_d = WP1;
      WP1:     state_d = WH1;
      WH1:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    n_oe_d = !((state_d == RD0) || (state_d == RD1));
    n_we_d = !((state_d == WP0) || (state_d == WP1));
    ack_d  = (state_d == DONE);
    busy_d = (state_d != IDLE);

    case (state_d)
      RD0, WS0: addr_d = base_s;
      RD1, WS1: addr_d = base_s + ADDR_W'(WORD_BYTES);
      default:  addr_d = addr_q;
    endcase

    case (state_d)
      WS0:     wdata_d = (state_q == IDLE) ? REQ_WDATA : merged0_s;
      WS1:     wdata_d = merged1_s;
      default: wdata_d = wdata_q;
    endcase

    if (((state_q == RD0) || (state_q == RD1)) && (state_d == DONE)) begin
      rdata_d = load_s;
    end else begin
      rdata_d = rdata_q;
    end
  end

  // State and registered outputs; async reset parks the bus idle with strobes high.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      req_we_q     <= 1'b0;
      req_size_q   <= SZ_BYTE;
      req_signed_q <= 1'b0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      split_q      <= 1'b0;
      word0_q      <= '0;
      word1_q      <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      n_oe_q       <= 1'b1;
      n_we_q       <= 1'b1;
      ack_q        <= 1'b0;
      fault_q      <= 1'b0;
      busy_q       <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      req_we_q     <= req_we_d;
      req_size_q   <= req_size_d;
      req_signed_q <= req_signed_d;
      req_addr_q   <= req_addr_d;
      req_wdata_q  <= req_wdata_d;
      split_q      <= split_d;
      word0_q      <= word0_d;
      word1_q      <= word1_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      n_oe_q       <= n_oe_d;
      n_we_q       <= n_we_d;
      ack_q        <= ack_d;
      fault_q      <= fault_d;
      busy_q       <= busy_d;
      rdata_q      <= rdata_d;
    end
  end

  assign ACK           = ack_q;
  assign FAULT         = fault_q;
  assign RDATA         = rdata_q;
  assign BUSY          = busy_q;
  assign bus.ADDR      = addr_q;
  assign bus.N_OE      = n_oe_q;
  assign bus.N_WE      = n_we_q;
  assign bus.MEM_WDATA = wdata_q;

endmodule

// File: doc/mem_initiator.md
Name: mem_initiator

Overview:
Bus master that drives the 32-bit word-wide memory responder interface (ADDR, N_WE, N_OE, write data, read data) on behalf of a CPU-side load/store request port. It converts byte, half and word requests at any byte address into aligned word cycles. Partial and unaligned writes use read-modify-write. Unaligned accesses that cross a word boundary split into two word cycles. The responder's read data is combinational while N_OE is low. Writes commit on the low N_WE strobe.

Parameters:
ADDR_W, 32, request/memory address width
DATA_W, 32, memory word width; fixed at 32, lane logic assumes 4 byte lanes

Ports:
CLK  in  1  single clock, all state on rising edge
RST  in  1  asynchronous, active-high reset
REQ  in  1  request strobe; sampled only in IDLE
REQ_WE  in  1  1=store, 0=load
REQ_SIZE  in  2  00 byte, 01 half, 10 word, 11 reserved
REQ_SIGNED  in  1  sign-extend loads (byte/half)
REQ_ADDR  in  32  byte address
REQ_WDATA  in  32  store data, right-justified
ACK  out  1  one-cycle completion pulse
FAULT  out  1  valid with ACK; request rejected, no memory access
RDATA  out  32  load result, right-justified and extended; valid with ACK, held until next ACK
BUSY  out  1  high from the cycle after acceptance through the ACK cycle
ADDR  out  32  memory word address; bits [1:0] always 0
N_OE  out  1  memory output enable, active low
N_WE  out  1  memory write enable, active low
MEM_WDATA  out  32  data to memory IN
MEM_RDATA  in  32  data from memory OUT

Behaviour:
- Reset (async): N_OE=1, N_WE=1, ADDR=0, MEM_WDATA=0, ACK=0, FAULT=0, BUSY=0, RDATA=0, state IDLE. A reset asserted mid-write raises N_WE immediately; that word's contents are undefined.
- Lanes are little-endian: byte k of a word is bits [8k+7:8k]. The first word address is REQ_ADDR & ~3. The second word address is first+4, wrapping mod 2^32.
- Span: nbytes=1/2/4. The access splits into two words when addr[1:0]+nbytes>4.
- Acceptance: REQ=1 in IDLE latches all REQ_* fields. REQ in any other state is ignored. A REQ still high in the cycle after ACK starts a new request.
- REQ_SIZE=11: ACK+FAULT in the cycle after acceptance. No memory cycle. RDATA is unchanged.
- States and transitions:
  - IDLE -> RD0 (loads; partial or split stores) or WS0 (aligned word store).
  - RD0: ADDR=word0, N_OE=0, MEM_RDATA captured at the clock edge -> RD1 if split, else WS0 (store) or DONE.
  - RD1: same as RD0 for word1 -> WS0 or DONE.
  - WS0 setup: ADDR and merged MEM_WDATA driven, N_WE=1.
  - WP0 strobe: N_WE=0.
  - WH0 hold: N_WE=1, address and data held. After WH0, go to WS1/WP1/WH1 (same pattern for word1) if split, else DONE.
  - DONE: ACK=1 -> IDLE.
- N_OE and N_WE are never low in the same cycle.
- ADDR and MEM_WDATA are stable for the whole of WSx/WPx/WHx.
- Latency from the acceptance cycle to ACK:
  - aligned word load: 2
  - split load: 3
  - aligned word store: 4
  - partial in-word store: 5
  - split store: 9
- Store merge: captured read words are overwritten only in the target byte lanes. Non-target lanes are rewritten with their original values.
- Load assembly: bytes are gathered across word0/word1, right-justified, then zero- or sign-extended from bit 7 or bit 15 per REQ_SIGNED. Word loads ignore REQ_SIGNED.

Optional Feature:
Macro ALIGN_FAULT_EN.
- Defined: non-naturally-aligned requests (half with addr[0]=1; word with addr[1:0]!=0) get ACK+FAULT in the cycle after acceptance with no memory cycle. Split states are never entered.
- Undefined: such requests are split or merged as described under Behaviour. FAULT is asserted only for SIZE=11.

Decomposition:
- Package mem_pkg:
  - size enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD)
  - state enum (IDLE, RD0, RD1, WS0, WP0, WH0, WS1, WP1, WH1, DONE)
  - WORD_BYTES=4 and lane-mask helper constants
- Sub-module mem_lane_merge (combinational):
  - store-lane masks and merged write words from addr[1:0], size, wdata and captured words
  - extended load result
- The FSM, address counter and capture registers stay in mem_initiator.

Test Plan:
- Aligned word load, REQ_ADDR=0x0000_0010, memory word=0xDEADBEEF -> one N_OE-low cycle at ADDR=0x10; ACK 2 cycles after acceptance; RDATA=0xDEADBEEF, FAULT=0.
- Signed byte load at 0x13 from word 0x80FF_0000 -> RDATA=0xFFFF_FF80; unsigned -> 0x0000_0080.
- Byte store 0xAB at 0x21 over word 0x1122_3344 -> RD0, then setup/strobe/hold at 0x20 with MEM_WDATA=0x1122_AB44; ACK at +5.
- Split word store 0xAABBCCDD at 0x0E, words at 0x0C/0x10 = 0x0 -> writes 0xCCDD_0000 to 0x0C and 0x0000_AABB to 0x10; ACK at +9. Check N_OE and N_WE never low together.
- Split half load at 0xFFFF_FFFF -> second read at ADDR=0x0000_0000 (wrap). With ALIGN_FAULT_EN the same request gives ACK+FAULT at +1 and N_OE stays 1.
- RST pulsed during WP0 -> N_WE=1, BUSY=0, ACK=0 asynchronously. SIZE=11 request -> FAULT=1 at +1, RDATA unchanged.
